// File: rtl/tpu_link_pkg.sv
// Shared definitions for the host command link: opcodes, FSM states,
// response constants and the STATUS byte layout.
package tpu_link_pkg;

  typedef enum logic [7:0] {
    OP_LOAD_W   = 8'h01,
    OP_LOAD_ACT = 8'h02,
    OP_START    = 8'h03,
    OP_READ_ACC = 8'h04,
    OP_STATUS   = 8'h05,
    OP_CLR_W    = 8'h06,
    OP_SET_RDY  = 8'h07
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARG,
    ST_WDATA,
    ST_ACT,
    ST_EXEC,
    ST_RESP
  } link_state_e;

  localparam logic [7:0] ACK_BYTE = 8'hA5;
  localparam logic [7:0] NAK_BYTE = 8'hEE;

  // STATUS byte layout: {ovf, err, weights_ready, 0, mlp_state[3:0]}
  localparam int STAT_OVF     = 7;
  localparam int STAT_ERR     = 6;
  localparam int STAT_RDY     = 5;
  localparam int STAT_MLP_LSB = 0;

  function automatic logic [7:0] status_byte(input logic ovf, input logic err,
                                             input logic rdy, input logic [3:0] mstate);
    logic [7:0] s;
    s = '0;
    s[STAT_OVF] = ovf;
    s[STAT_ERR] = err;
    s[STAT_RDY] = rdy;
    s[STAT_MLP_LSB +: 4] = mstate;
    return s;
  endfunction

endpackage

// File: rtl/tpu_link_txser.sv
// Shadow-load byte serialiser: captures a W-bit word on load and presents
// bytes LSB first over a valid/ready handshake, up to byte index load_last.
module tpu_link_txser #(
  parameter int W  = 8,
  parameter int IW = ((W / 8) > 1) ? $clog2(W / 8) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [W-1:0]  load_word,
  input  logic [IW-1:0] load_last,
  input  logic          tx_ready,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  output logic          done
);

  localparam int NB = W / 8;

  logic [NB-1:0][7:0] shadow;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      last;
  logic [IW-1:0]      idx_inc;

  assign idx_inc = idx + 1'b1;
  assign done    = tx_valid && tx_ready && (idx == last);

  // Shadow word capture; the byte stream reads only from this copy.
  // NOTE: the shadow is deliberately not reset -- it is always written by a
  // load before any byte of it is presented, so a reset would only cost muxes.
  always_ff @(posedge clk) begin
    if (load) shadow <= load_word;
  end

  // Byte presentation: hold while stalled, advance one byte per handshake.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
      idx      <= '0;
      last     <= '0;
    end else if (load) begin
      tx_valid <= 1'b1;
      tx_data  <= load_word[7:0];
      idx      <= '0;
      last     <= load_last;
    end else if (tx_valid && tx_ready) begin
      if (idx == last) begin
        tx_valid <= 1'b0;
      end else begin
        idx     <= idx_inc;
        tx_data <= shadow[idx_inc];
      end
    end
  end

endmodule

// File: rtl/tpu_host_link.sv
// Host command front-end: decodes opcode/payload packets from the UART byte
// stream, drives weight-FIFO/activation/start controls and returns
// ACK/NAK, status and accumulator snapshots through the TX serialiser.
module tpu_host_link
  import tpu_link_pkg::*;
#(
  parameter int NUM_COLS = 2,
  parameter int ACC_W    = 32,
  parameter int ACT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic                      tx_valid,
  output logic [7:0]                tx_data,
  input  logic                      tx_ready,
  output logic [NUM_COLS-1:0]       wf_push,
  output logic [7:0]                wf_data,
  output logic                      wf_reset,
  output logic                      act_valid,
  output logic [ACT_W-1:0]          act_data,
  output logic                      start_mlp,
  output logic                      weights_ready,
  input  logic [3:0]                mlp_state,
  input  logic [NUM_COLS*ACC_W-1:0] acc_in,
  input  logic                      acc_valid
);

  localparam int SNAP_W = NUM_COLS * ACC_W;
  localparam int SNAP_B = SNAP_W / 8;
  localparam int TX_IW  = (SNAP_B > 1) ? $clog2(SNAP_B) : 1;
  localparam int ACT_B  = ACT_W / 8;
  localparam int ACT_IW = (ACT_B > 1) ? $clog2(ACT_B) : 1;

  link_state_e           state, state_nxt;
  logic [7:0]            op;
  logic                  arg_sel;
  logic [7:0]            col;
  logic [7:0]            cnt;
  logic [ACT_B-1:0][7:0] act_buf, act_word;
  logic [ACT_IW-1:0]     act_idx;
  logic [SNAP_W-1:0]     snapshot;
  logic                  ovf, err;
  logic                  col_ok;

  logic                  push_en, act_en, start_en, clr_en, set_rdy;
  logic                  tx_load, nak, drop, tx_done, status_acc;
  logic [SNAP_W-1:0]     tx_word;
  logic [TX_IW-1:0]      tx_last;

  assign col_ok     = (col < 8'(NUM_COLS));
  assign status_acc = (state == ST_RESP) && (op == OP_STATUS) && tx_done;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state and one-cycle control decode.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    push_en   = 1'b0;
    act_en    = 1'b0;
    start_en  = 1'b0;
    clr_en    = 1'b0;
    set_rdy   = 1'b0;
    tx_load   = 1'b0;
    tx_word   = '0;
    tx_last   = '0;
    nak       = 1'b0;
    drop      = 1'b0;
    act_word  = act_buf;
    act_word[act_idx] = rx_data;
    case (state)
      ST_IDLE: begin
        if (rx_valid) begin
          case (opcode_e'(rx_data))
            OP_LOAD_W:   state_nxt = ST_ARG;
            OP_LOAD_ACT: state_nxt = ST_ACT;
            OP_START: begin
              start_en  = weights_ready;
              state_nxt = ST_EXEC;
            end
            OP_CLR_W: begin
              clr_en    = 1'b1;
              state_nxt = ST_EXEC;
            end
            OP_SET_RDY: begin
              set_rdy   = 1'b1;
              state_nxt = ST_EXEC;
            end
            default:     state_nxt = ST_EXEC;
          endcase
        end
      end
      ST_ARG: begin
        if (rx_valid && arg_sel) state_nxt = ST_WDATA;
      end
      ST_WDATA: begin
        if (rx_valid) begin
          push_en = col_ok;
          if (cnt == 8'd0) begin
            state_nxt = ST_RESP;
            tx_load   = 1'b1;
            tx_word   = SNAP_W'(col_ok ? ACK_BYTE : NAK_BYTE);
            nak       = !col_ok;
          end
        end
      end
      ST_ACT: begin
        if (rx_valid && (act_idx == ACT_IW'(ACT_B - 1))) begin
          act_en    = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        drop      = rx_valid;
        tx_load   = 1'b1;
        state_nxt = ST_RESP;
        case (opcode_e'(op))
          OP_START: begin
            tx_word = SNAP_W'(weights_ready ? ACK_BYTE : NAK_BYTE);
            nak     = !weights_ready;
          end
          OP_READ_ACC: begin
            tx_word = acc_valid ? acc_in : snapshot;
            tx_last = TX_IW'(SNAP_B - 1);
          end
          OP_STATUS:
            tx_word = SNAP_W'(status_byte(ovf, err, weights_ready, mlp_state));
          OP_LOAD_ACT, OP_CLR_W, OP_SET_RDY:
            tx_word = SNAP_W'(ACK_BYTE);
          default: begin
            tx_word = SNAP_W'(NAK_BYTE);
            nak     = 1'b1;
          end
        endcase
      end
      ST_RESP: begin
        drop = rx_valid;
        if (tx_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Packet field capture, registered control outputs and sticky flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op            <= '0;
      arg_sel       <= 1'b0;
      col           <= '0;
      cnt           <= '0;
      act_buf       <= '0;
      act_idx       <= '0;
      wf_push       <= '0;
      wf_data       <= '0;
      wf_reset      <= 1'b0;
      act_valid     <= 1'b0;
      act_data      <= '0;
      start_mlp     <= 1'b0;
      weights_ready <= 1'b0;
      ovf           <= 1'b0;
      err           <= 1'b0;
    end else begin
      wf_push   <= '0;
      wf_reset  <= clr_en;
      act_valid <= act_en;
      start_mlp <= start_en;
      if (state == ST_IDLE && rx_valid) begin
        op      <= rx_data;
        arg_sel <= 1'b0;
        act_idx <= '0;
      end
      if (state == ST_ARG && rx_valid) begin
        if (!arg_sel) begin
          col     <= rx_data;
          arg_sel <= 1'b1;
        end else begin
          cnt <= rx_data - 8'd1;  // N=0 wraps to 255 remaining: 256 bytes
        end
      end
      if (state == ST_WDATA && rx_valid) cnt <= cnt - 8'd1;
      if (push_en) begin
        wf_push <= NUM_COLS'(1) << col;
        wf_data <= rx_data;
      end
      if (state == ST_ACT && rx_valid) begin
        act_buf <= act_word;
        act_idx <= act_idx + 1'b1;
      end
      if (act_en) act_data <= act_word;
      if (set_rdy) weights_ready <= 1'b1;
      if (clr_en)  weights_ready <= 1'b0;
      // Clear on STATUS acceptance first so a same-cycle event still sticks.
      if (status_acc) begin
        ovf <= 1'b0;
        err <= 1'b0;
      end
      if (drop) ovf <= 1'b1;
      if (nak)  err <= 1'b1;
    end
  end

  // Accumulator snapshot follows every acc_valid, independent of the FSM.
  always_ff @(posedge clk) begin
    if (!rst)           snapshot <= '0;
    else if (acc_valid) snapshot <= acc_in;
  end

  tpu_link_txser #(
    .W  (SNAP_W),
    .IW (TX_IW)
  ) u_txser (
    .clk       (clk),
    .rst       (rst),
    .load      (tx_load),
    .load_word (tx_word),
    .load_last (tx_last),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .done      (tx_done)
  );

endmodule

// File: tb/tb_tpu_host_link.sv
// Self-checking bench for tpu_host_link: response bytes are predicted into a
// scoreboard queue when commands are sent and compared as the TX side
// accepts them; control strobes are checked at their expected cycle.
module tb_tpu_host_link;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [1:0]  wf_push;
  logic [7:0]  wf_data;
  logic        wf_reset;
  logic        act_valid;
  logic [15:0] act_data;
  logic        start_mlp;
  logic        weights_ready;
  logic [3:0]  mlp_state;
  logic [63:0] acc_in;
  logic        acc_valid;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  sb[$];
  int          ready_mode = 0;  // 0: always ready, 1: toggle, 2: stalled
  int          start_cnt  = 0;
  bit          hold_pend  = 1'b0;
  logic [7:0]  held;

  always #5 clk = ~clk;

  tpu_host_link #(.NUM_COLS(2), .ACC_W(32), .ACT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .wf_push       (wf_push),
    .wf_data       (wf_data),
    .wf_reset      (wf_reset),
    .act_valid     (act_valid),
    .act_data      (act_data),
    .start_mlp     (start_mlp),
    .weights_ready (weights_ready),
    .mlp_state     (mlp_state),
    .acc_in        (acc_in),
    .acc_valid     (acc_valid)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // TX ready pattern generator.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // TX monitor: hold-stability check and scoreboard compare on handshakes.
  always @(negedge clk) begin
    if (rst) begin
      if (hold_pend) check("tx_hold", {55'd0, tx_valid, tx_data}, {55'd0, 1'b1, held});
      hold_pend = tx_valid && !tx_ready;
      held      = tx_data;
      if (tx_valid && tx_ready) begin
        check("tx_pending", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) check("tx_byte", 64'(tx_data), 64'(sb.pop_front()));
      end
      if (start_mlp) start_cnt++;
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic expect_bytes(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) sb.push_back(v[8*i +: 8]);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !tx_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain", 64'(ok), 64'd1);
  endtask

  task automatic status(input logic [7:0] exp);
    expect_bytes(64'(exp), 1);
    send(8'h05);
    drain();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ctl"},
          64'({tx_valid, wf_push, wf_reset, act_valid, start_mlp, weights_ready}), 64'd0);
    check({tag, "_data"}, {32'd0, tx_data, wf_data, act_data}, 64'd0);
  endtask

  initial begin
    rst = 1'b0; rx_valid = 1'b0; rx_data = '0;
    mlp_state = '0; acc_in = '0; acc_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // START without weights: NAK, err visible once in STATUS.
    expect_bytes(64'hEE, 1);
    send(8'h03);
    check("start_nak_pulse", 64'(start_mlp), 64'd0);
    drain();
    status(8'h40);
    status(8'h00);

    // SET_RDY then START: ACK, ACK and exactly one start pulse.
    expect_bytes(64'hA5, 1);
    send(8'h07);
    drain();
    check("weights_ready_set", 64'(weights_ready), 64'd1);
    expect_bytes(64'hA5, 1);
    send(8'h03);
    check("start_pulse", 64'(start_mlp), 64'd1);
    @(posedge clk); #1;
    check("start_pulse_end", 64'(start_mlp), 64'd0);
    drain();
    check("start_count", 64'(start_cnt), 64'd1);
    status(8'h20);

    // LOAD_W column 1, three back-to-back data bytes.
    expect_bytes(64'hA5, 1);
    send(8'h01); send(8'h01); send(8'h03);
    send(8'h11); check("push0", {wf_push, wf_data}, {2'b10, 8'h11});
    send(8'h22); check("push1", {wf_push, wf_data}, {2'b10, 8'h22});
    send(8'h33); check("push2", {wf_push, wf_data}, {2'b10, 8'h33});
    @(posedge clk); #1;
    check("push_end", 64'(wf_push), 64'd0);
    drain();

    // LOAD_W to a nonexistent column: bytes swallowed, NAK.
    expect_bytes(64'hEE, 1);
    send(8'h01); send(8'h05); send(8'h02);
    send(8'hAA); check("bad_col_push0", 64'(wf_push), 64'd0);
    send(8'hBB); check("bad_col_push1", 64'(wf_push), 64'd0);
    drain();
    status(8'h60);

    // Unknown opcode: NAK and err.
    expect_bytes(64'hEE, 1);
    send(8'h09);
    drain();
    status(8'h60);

    // READ_ACC with a stalling TX and a mid-stream acc_valid.
    acc_in = {32'h0000_0002, 32'hDEAD_BEEF}; acc_valid = 1'b1;
    @(posedge clk); #1;
    acc_valid = 1'b0;
    ready_mode = 1;
    expect_bytes({32'h0000_0002, 32'hDEAD_BEEF}, 8);
    send(8'h04);
    repeat (5) @(posedge clk);
    #1;
    acc_in = 64'hCAFE_F00D_0BAD_1DEA; acc_valid = 1'b1;
    @(posedge clk); #1;
    acc_valid = 1'b0;
    drain();
    ready_mode = 0;
    expect_bytes(64'hCAFE_F00D_0BAD_1DEA, 8);
    send(8'h04);
    drain();

    // acc_valid coinciding with READ_ACC entry goes straight to the shadow.
    expect_bytes(64'h1122_3344_5566_7788, 8);
    send(8'h04);
    acc_in = 64'h1122_3344_5566_7788; acc_valid = 1'b1;
    @(posedge clk); #1;
    acc_valid = 1'b0;
    drain();

    // LOAD_ACT with a byte injected while the ACK is stalled.
    ready_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    expect_bytes(64'hA5, 1);
    send(8'h02); send(8'h34);
    check("act_early", 64'(act_valid), 64'd0);
    send(8'h12);
    check("act_pulse", {act_valid, act_data}, {1'b1, 16'h1234});
    @(posedge clk); #1;
    check("act_pulse_end", 64'(act_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    send(8'h55);
    ready_mode = 0;
    drain();
    status(8'hA0);

    // CLR_W: wf_reset pulse, weights_ready cleared.
    expect_bytes(64'hA5, 1);
    send(8'h06);
    check("wf_reset_pulse", {wf_reset, weights_ready}, {1'b1, 1'b0});
    @(posedge clk); #1;
    check("wf_reset_end", 64'(wf_reset), 64'd0);
    drain();

    // Reset in the middle of LOAD_W, then a clean STATUS.
    send(8'h01); send(8'h00); send(8'h04);
    send(8'h01); send(8'h02);
    check("pre_reset_push", 64'(wf_push), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_values("midreset");
    rst = 1'b1;
    mlp_state = 4'h3;
    status(8'h03);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
